inst_rom_loader: RTL and testbench

- Responder side of the core's instruction-fetch interface. Answers ce/addr fetch requests with 32-bit instruction words.
- Contents are filled at boot by a byte-serial valid/ready loader that packs bytes into big-endian words.
- Sits outside the core: the core's ROM address and chip-enable outputs drive this block, and this block's inst output drives the core's ROM data input.
- boot_done gates the core's reset at top level.

---
 rtl/inst_rom_loader_if.sv | 41 ++++
 rtl/inst_rom_loader.sv | 125 ++++++++++++
 tb/tb_inst_rom_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_loader_if.sv
// -----------------------------------------------------------------------------
// inst_rom_loader_if
// Bundles the instruction-fetch bus and the byte-serial boot loader bus of the
// instruction ROM.
//   master : the core/boot host side (drives ce, addr, load_valid, load_byte,
//            load_last; observes inst, load_ready, boot_done, word_count)
//   slave  : the ROM side (inst_rom_loader)
// Signals:
//   ce          fetch enable from the core
//   addr[31:0]  byte address from the core
//   inst[31:0]  instruction word returned to the core
//   load_valid  loader byte valid
//   load_byte   loader data byte
//   load_last   final byte of the image (qualified by load_valid)
//   load_ready  ROM accepts a byte this cycle
//   boot_done   image loaded; the core may run
//   word_count  number of words written since reset
// -----------------------------------------------------------------------------
interface inst_rom_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  ce;
  logic [31:0]           addr;
  logic [31:0]           inst;
  logic                  load_valid;
  logic [7:0]            load_byte;
  logic                  load_last;
  logic                  load_ready;
  logic                  boot_done;
  logic [ADDR_WIDTH:0]   word_count;

  modport master (
    output ce, addr, load_valid, load_byte, load_last,
    input  inst, load_ready, boot_done, word_count
  );

  modport slave (
    input  ce, addr, load_valid, load_byte, load_last,
    output inst, load_ready, boot_done, word_count
  );
endinterface

// File: rtl/inst_rom_loader.sv
// -----------------------------------------------------------------------------
// inst_rom_loader
// Instruction ROM answering the core's ce/addr fetches with 32-bit words. At
// boot it is filled by a byte-serial valid/ready loader; bytes are packed
// big-endian (first byte of a word lands in bits [31:24]). Once the image is
// complete (load_last, or the memory is full) the block enters RUN, raises
// boot_done and stops accepting bytes until the next reset.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  inst_rom_loader_if.slave (fetch bus + loader bus, see interface)
// Parameters:
//   ADDR_WIDTH  log2 of memory depth in words
//   DEPTH       number of words, must equal 2**ADDR_WIDTH
// -----------------------------------------------------------------------------
module inst_rom_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  inst_rom_loader_if.slave        bus
);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                r_state, w_state_next;
  logic [1:0]            r_byte_idx, w_byte_idx_next;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, w_wr_ptr_next;
  logic [ADDR_WIDTH:0]   r_word_count, w_word_count_next;
  logic [31:0]           r_asm, w_asm_next;
  logic                  w_write;
  logic [31:0]           w_word;

  // Memory is deliberately not reset; only the pointers are.
  logic [31:0]           r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LOAD;
      r_byte_idx   <= 2'd0;
      r_wr_ptr     <= '0;
      r_word_count <= '0;
      r_asm        <= 32'h0;
    end else begin
      r_state      <= w_state_next;
      r_byte_idx   <= w_byte_idx_next;
      r_wr_ptr     <= w_wr_ptr_next;
      r_word_count <= w_word_count_next;
      r_asm        <= w_asm_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_byte_idx_next   = r_byte_idx;
    w_wr_ptr_next     = r_wr_ptr;
    w_word_count_next = r_word_count;
    w_asm_next        = r_asm;
    w_write           = 1'b0;
    // Current byte merged into the partial word at its big-endian lane. Lanes
    // not yet filled are still zero, which gives the padding for a short
    // final word for free.
    w_word            = r_asm | ({bus.load_byte, 24'h000000} >> {r_byte_idx, 3'b000});

    case (r_state)
      LOAD: begin
        if (bus.load_valid) begin
          w_byte_idx_next = r_byte_idx + 2'd1;
          w_asm_next      = w_word;
          if (r_byte_idx == 2'd3 || bus.load_last) begin
            w_write           = 1'b1;
            w_asm_next        = 32'h0;
            w_wr_ptr_next     = r_wr_ptr + ADDR_WIDTH'(1);
            w_word_count_next = r_word_count + (ADDR_WIDTH + 1)'(1);
            // Stopping at the last slot prevents the pointer wrap from ever
            // overwriting word 0.
            if (bus.load_last || r_wr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
              w_state_next = RUN;
            end
          end
        end
      end
      RUN: begin
        // Loader input is ignored until the next reset.
      end
      default: w_state_next = LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory write; a byte arriving together with reset is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_write && !rst) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // Read is combinational so the core's IF/ID register captures the word in
  // the same cycle it presents the address. Outside RUN a NOP (zero) is
  // returned so the core never sees a half-loaded image.
  // ---------------------------------------------------------------------------
  assign bus.inst       = (bus.ce && r_state == RUN) ? r_mem[bus.addr[ADDR_WIDTH+1:2]] : 32'h0;
  assign bus.load_ready = (r_state == LOAD);
  assign bus.boot_done  = (r_state == RUN);
  assign bus.word_count = r_word_count;

  // Byte-offset bits and bits above the memory range do not take part in
  // decoding; high addresses alias onto the ROM.
  logic w_unused_addr;
  assign w_unused_addr = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

endmodule

// File: tb/tb_inst_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_loader
// Drives the loader and fetch buses of a small (4-word) inst_rom_loader. Each
// cycle the stimulus pushes the expected outputs for that cycle into a queue,
// computed from a reference model of the boot image (byte stream -> packed
// big-endian words). A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_inst_rom_loader;

  localparam int AW  = 2;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  inst_rom_loader_if #(.ADDR_WIDTH(AW)) bus ();

  inst_rom_loader #(
    .ADDR_WIDTH(AW),
    .DEPTH     (DEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] inst;
    bit          chk_inst;
    logic [AW:0] wc;
    bit          done;
  } probe_t;

  probe_t probe_q[$];
  int     n_vec  = 0;
  int     n_miss = 0;

  // Reference model: words of the image being loaded since the last reset.
  logic [31:0] m_mem [DEP];
  int          m_nacc;   // bytes accepted since reset
  int          m_wc;     // words written since reset
  bit          m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs of the cycle whose expectation was queued.
  always @(negedge clk) begin : monitor
    probe_t p;
    if (probe_q.size() != 0) begin
      p = probe_q.pop_front();
      if (p.chk_inst) check("inst", bus.inst, p.inst);
      check("word_count", 32'(bus.word_count), 32'(p.wc));
      check("boot_done", 32'(bus.boot_done), 32'(p.done));
      check("load_ready", 32'(bus.load_ready), 32'(!p.done));
    end
  end

  function automatic bit rbit();
    return ($urandom() & 32'd1) != 0;
  endfunction

  // One clock cycle of stimulus. Expected outputs reflect the state before
  // the rising edge; the model is then advanced across that edge.
  task automatic cycle(input bit v, input logic [7:0] b, input bit l, input bit r,
                       input bit c, input logic [31:0] a,
                       input bit use_exp, input logic [31:0] exp_inst);
    probe_t p;
    int     idx, k, w;
    bus.load_valid = v;
    bus.load_byte  = b;
    bus.load_last  = l;
    rst            = r;
    bus.ce         = c;
    bus.addr       = a;
    idx            = int'(a[AW+1:2]);
    p.done         = m_done;
    p.wc           = (AW + 1)'(m_wc);
    if (use_exp) begin
      p.inst = exp_inst; p.chk_inst = 1'b1;
    end else if (!(c && m_done)) begin
      p.inst = 32'h0; p.chk_inst = 1'b1;
    end else if (idx < m_wc) begin
      p.inst = m_mem[idx]; p.chk_inst = 1'b1;
    end else begin
      p.inst = 32'h0; p.chk_inst = 1'b0;   // never written this boot
    end
    probe_q.push_back(p);

    if (r) begin
      m_nacc = 0; m_wc = 0; m_done = 1'b0;
    end else if (v && !m_done) begin
      k = m_nacc % 4;
      w = m_nacc / 4;
      if (k == 0) m_mem[w] = 32'h0;
      m_mem[w] = m_mem[w] | (32'(b) << (24 - 8 * k));
      m_nacc++;
      if (l || k == 3) m_wc++;
      if (l || m_nacc == 4 * DEP) m_done = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit l);
    cycle(1'b1, b, l, 1'b0, rbit(), $urandom(), 1'b0, 32'h0);
  endtask

  task automatic idle();
    cycle(1'b0, 8'($urandom()), rbit(), 1'b0, rbit(), $urandom(), 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 8'($urandom()), 1'b0, 1'b1, rbit(), $urandom(), 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(1'b0, 8'($urandom()), 1'b0, 1'b0, 1'b1, a, 1'b0, 32'h0);
  endtask

  task automatic rd_exp(input logic [31:0] a, input logic [31:0] e);
    cycle(1'b0, 8'($urandom()), 1'b0, 1'b0, 1'b1, a, 1'b1, e);
  endtask

  function automatic logic [31:0] alias_addr(input int w);
    return ($urandom() << (AW + 2)) | (32'(w) << 2) | ($urandom() & 32'd3);
  endfunction

  logic [7:0] t1 [8] = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
  logic [7:0] rb [16];

  initial begin
    int n;
    rst            = 1'b1;
    bus.ce         = 1'b0;
    bus.addr       = 32'h0;
    bus.load_valid = 1'b0;
    bus.load_byte  = 8'h0;
    bus.load_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_nacc = 0; m_wc = 0; m_done = 1'b0;
    do_reset();

    // Two-word image, last on the 8th byte.
    for (int i = 0; i < 8; i++) send(t1[i], i == 7);
    rd_exp(32'h4, 32'h34020020);
    rd_exp(32'h5, 32'h34020020);
    rd_exp(32'h0, 32'h34011100);
    rd_exp(32'h3 | (32'h1 << 4), 32'h34011100);
    cycle(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 32'h4, 1'b1, 32'h0);
    $display("image directed: 8 bytes, %0d words", m_wc);

    // Partial last word is zero-padded.
    do_reset();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    idle();
    rd_exp(32'h0, 32'hAABB0000);
    // RUN ignores the loader and gates on ce.
    for (int i = 0; i < 3; i++) send(8'hFF, rbit());
    rd_exp(32'h0, 32'hAABB0000);
    cycle(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    $display("image partial: 2 bytes, %0d words", m_wc);

    // Full memory without load_last; extra bytes must be ignored.
    do_reset();
    cycle(1'b0, 8'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0);  // LOAD returns NOP
    for (int i = 0; i < 16; i++) begin
      rb[i] = 8'($urandom());
      send(rb[i], 1'b0);
    end
    send(8'h5A, 1'b0);
    send(8'hA5, 1'b1);
    rd_exp(32'h10, {rb[0], rb[1], rb[2], rb[3]});
    rd_exp(32'hC, {rb[12], rb[13], rb[14], rb[15]});
    for (int w = 0; w < DEP; w++) rd(alias_addr(w));
    $display("image full: 16 bytes, %0d words", m_wc);

    // Reset mid-word, with a byte offered in the reset cycle.
    do_reset();
    for (int i = 0; i < 6; i++) send(8'($urandom()), 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    rd_exp(32'h0, 32'h11223344);
    $display("image after mid-load reset: 4 bytes, %0d words", m_wc);

    // Directed image with idle gaps between every byte.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle();
      send(t1[i], i == 7);
    end
    rd_exp(32'h4, 32'h34020020);
    rd_exp(32'h0, 32'h34011100);
    $display("image gapped: 8 bytes, %0d words", m_wc);

    // Randomised images with random gaps.
    for (int it = 0; it < 24; it++) begin
      do_reset();
      n = int'($urandom_range(1, 4 * DEP + 3));
      for (int i = 0; i < n; i++) begin
        if (rbit()) idle();
        send(8'($urandom()), i == n - 1);
      end
      idle();
      for (int w = 0; w < m_wc; w++) rd(alias_addr(w));
      cycle(1'b0, 8'($urandom()), 1'b0, 1'b0, 1'b0, $urandom(), 1'b0, 32'h0);
      $display("image %0d: %0d bytes, %0d words", it, n, m_wc);
    end

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
